// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage CPU pipeline.
// Holds the datapath defaults, the ALU op codes and the forwarding-select encoding.
package cpu_pkg;

   localparam int CPU_DW = 32;
   localparam int CPU_RW = 5;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_MUL = 4'd3;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// One EX-stage operand forwarding mux: picks the newest value of a source register
// from EX/MEM, then MEM/WB, falling back to the value captured in ID/EX.
module fwd_mux
   import cpu_pkg::*;
#(
   parameter int DW = CPU_DW,
   parameter int RW = CPU_RW
) (
   input  logic [RW-1:0] idx_i,
   input  logic [DW-1:0] reg_val_i,
   input  logic          mem_regwrite_i,
   input  logic [RW-1:0] mem_rd_i,
   input  logic [DW-1:0] mem_result_i,
   input  logic          wb_regwrite_i,
   input  logic [RW-1:0] wb_rd_i,
   input  logic [DW-1:0] wb_result_i,
   output logic [DW-1:0] val_o
);

   fwd_sel_e sel;
   logic     mem_hit;
   logic     wb_hit;

   // Register 0 is hardwired to zero, so a write to it never forwards.
   assign mem_hit = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == idx_i);
   assign wb_hit  = wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == idx_i);

   always_comb begin
      sel = FWD_REG;
      if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
   end

   always_comb begin
      val_o = reg_val_i;
      case (sel)
         FWD_MEM: val_o = mem_result_i;
         FWD_WB:  val_o = wb_result_i;
         default: val_o = reg_val_i;
      endcase
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with WB write-through, EX operand forwarding and
// load-use stall detection; drives the EX-stage ALU operands directly.
module ex_operand_stage
   import cpu_pkg::*;
#(
   parameter int DW = CPU_DW,
   parameter int RW = CPU_RW
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          id_valid_i,
   input  logic [RW-1:0] id_rs_i,
   input  logic [RW-1:0] id_rt_i,
   input  logic [RW-1:0] id_rd_i,
   input  logic [DW-1:0] id_rs_data_i,
   input  logic [DW-1:0] id_rt_data_i,
   input  logic [DW-1:0] id_imm_i,
   input  logic [3:0]    id_alu_ctrl_i,
   input  logic          id_alusrc_i,
   input  logic          id_regwrite_i,
   input  logic          id_memread_i,
   input  logic          id_memwrite_i,
   input  logic          id_memtoreg_i,
   input  logic          flush_i,
   input  logic          mem_regwrite_i,
   input  logic [RW-1:0] mem_rd_i,
   input  logic [DW-1:0] mem_result_i,
   input  logic          wb_regwrite_i,
   input  logic [RW-1:0] wb_rd_i,
   input  logic [DW-1:0] wb_result_i,
   output logic [DW-1:0] src1_o,
   output logic [DW-1:0] src2_o,
   output logic [3:0]    alu_ctrl_o,
   output logic [DW-1:0] store_data_o,
   output logic [RW-1:0] ex_rd_o,
   output logic          ex_valid_o,
   output logic          ex_regwrite_o,
   output logic          ex_memread_o,
   output logic          ex_memwrite_o,
   output logic          ex_memtoreg_o,
   output logic          stall_o
);

   logic          valid_q,    valid_d;
   logic [RW-1:0] rs_q,       rs_d;
   logic [RW-1:0] rt_q,       rt_d;
   logic [RW-1:0] rd_q,       rd_d;
   logic [DW-1:0] rs_data_q,  rs_data_d;
   logic [DW-1:0] rt_data_q,  rt_data_d;
   logic [DW-1:0] imm_q,      imm_d;
   logic [3:0]    alu_ctrl_q, alu_ctrl_d;
   logic          alusrc_q,   alusrc_d;
   logic          regwrite_q, regwrite_d;
   logic          memread_q,  memread_d;
   logic          memwrite_q, memwrite_d;
   logic          memtoreg_q, memtoreg_d;

   logic          load_use;
   logic          wt_rs;
   logic          wt_rt;
   logic [DW-1:0] fwd_a;
   logic [DW-1:0] fwd_b;

   // rt is compared even for I-type instructions; a spurious stall only costs a cycle.
   assign load_use = valid_q && memread_q && (rd_q != '0)
                     && ((rd_q == id_rs_i) || (rd_q == id_rt_i)) && id_valid_i;
   assign stall_o  = load_use;

   // The register file is read in ID before WB writes it, so bypass that write here.
   assign wt_rs = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == id_rs_i);
   assign wt_rt = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == id_rt_i);

   always_comb begin
      valid_d    = 1'b0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
      alu_ctrl_d = '0;
      alusrc_d   = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      if (!flush_i && !load_use) begin
         valid_d    = id_valid_i;
         rs_d       = id_rs_i;
         rt_d       = id_rt_i;
         rd_d       = id_rd_i;
         rs_data_d  = wt_rs ? wb_result_i : id_rs_data_i;
         rt_data_d  = wt_rt ? wb_result_i : id_rt_data_i;
         imm_d      = id_imm_i;
         alu_ctrl_d = id_alu_ctrl_i;
         alusrc_d   = id_alusrc_i;
         regwrite_d = id_regwrite_i;
         memread_d  = id_memread_i;
         memwrite_d = id_memwrite_i;
         memtoreg_d = id_memtoreg_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q    <= 1'b0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         alu_ctrl_q <= '0;
         alusrc_q   <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         imm_q      <= imm_d;
         alu_ctrl_q <= alu_ctrl_d;
         alusrc_q   <= alusrc_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         memtoreg_q <= memtoreg_d;
      end
   end

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
      .idx_i          (rs_q),
      .reg_val_i      (rs_data_q),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_rd_i       (mem_rd_i),
      .mem_result_i   (mem_result_i),
      .wb_regwrite_i  (wb_regwrite_i),
      .wb_rd_i        (wb_rd_i),
      .wb_result_i    (wb_result_i),
      .val_o          (fwd_a)
   );

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
      .idx_i          (rt_q),
      .reg_val_i      (rt_data_q),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_rd_i       (mem_rd_i),
      .mem_result_i   (mem_result_i),
      .wb_regwrite_i  (wb_regwrite_i),
      .wb_rd_i        (wb_rd_i),
      .wb_result_i    (wb_result_i),
      .val_o          (fwd_b)
   );

   assign src1_o        = fwd_a;
   assign src2_o        = alusrc_q ? imm_q : fwd_b;
   assign store_data_o  = fwd_b;
   assign alu_ctrl_o    = alu_ctrl_q;
   assign ex_rd_o       = rd_q;
   assign ex_valid_o    = valid_q;
   assign ex_regwrite_o = regwrite_q;
   assign ex_memread_o  = memread_q;
   assign ex_memwrite_o = memwrite_q;
   assign ex_memtoreg_o = memtoreg_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed pipeline scenarios followed by randomized traffic checked against a
// behavioural model of the ID/EX register, forwarding and load-use rules.
module tb_ex_operand_stage;
   import cpu_pkg::*;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          id_valid_i;
   logic [RW-1:0] id_rs_i, id_rt_i, id_rd_i;
   logic [DW-1:0] id_rs_data_i, id_rt_data_i, id_imm_i;
   logic [3:0]    id_alu_ctrl_i;
   logic          id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i;
   logic          flush_i;
   logic          mem_regwrite_i;
   logic [RW-1:0] mem_rd_i;
   logic [DW-1:0] mem_result_i;
   logic          wb_regwrite_i;
   logic [RW-1:0] wb_rd_i;
   logic [DW-1:0] wb_result_i;
   logic [DW-1:0] src1_o, src2_o, store_data_o;
   logic [3:0]    alu_ctrl_o;
   logic [RW-1:0] ex_rd_o;
   logic          ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o;
   logic          stall_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   ex_operand_stage #(.DW(DW), .RW(RW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
      .id_alu_ctrl_i(id_alu_ctrl_i), .id_alusrc_i(id_alusrc_i), .id_regwrite_i(id_regwrite_i),
      .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
      .flush_i(flush_i),
      .mem_regwrite_i(mem_regwrite_i), .mem_rd_i(mem_rd_i), .mem_result_i(mem_result_i),
      .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i), .wb_result_i(wb_result_i),
      .src1_o(src1_o), .src2_o(src2_o), .alu_ctrl_o(alu_ctrl_o), .store_data_o(store_data_o),
      .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o), .ex_regwrite_o(ex_regwrite_o),
      .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o),
      .stall_o(stall_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic idle();
      id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; id_rd_i = 0;
      id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0; id_alu_ctrl_i = 0;
      id_alusrc_i = 0; id_regwrite_i = 0; id_memread_i = 0; id_memwrite_i = 0; id_memtoreg_i = 0;
      flush_i = 0;
      mem_regwrite_i = 0; mem_rd_i = 0; mem_result_i = 0;
      wb_regwrite_i = 0; wb_rd_i = 0; wb_result_i = 0;
   endtask

   // ctl = {alusrc, regwrite, memread, memwrite, memtoreg}
   task automatic set_id(input int rs, input int rt, input int rd, input logic [DW-1:0] rsd,
                         input logic [DW-1:0] rtd, input logic [3:0] alu, input logic [4:0] ctl);
      id_valid_i = 1; id_rs_i = RW'(rs); id_rt_i = RW'(rt); id_rd_i = RW'(rd);
      id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = 32'h4; id_alu_ctrl_i = alu;
      {id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i} = ctl;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [63:0] all_outs();
      return {src1_o | src2_o | store_data_o, 4'(alu_ctrl_o), 5'(ex_rd_o), ex_valid_o,
              ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, stall_o};
   endfunction

   function automatic logic [13:0] ctrl_outs();
      return {ex_valid_o, ex_rd_o, alu_ctrl_o, ex_regwrite_o, ex_memread_o,
              ex_memwrite_o, ex_memtoreg_o};
   endfunction

   // Behavioural model of the instruction sitting in EX.
   typedef struct {
      bit valid; int rs; int rt; int rd;
      bit [31:0] rs_data; bit [31:0] rt_data; bit [31:0] imm;
      int alu; bit alusrc; bit regwrite; bit memread; bit memwrite; bit memtoreg;
   } ex_t;

   ex_t m;

   function automatic bit [31:0] newest(int idx, bit [31:0] held);
      if (idx == 0) return held;
      if (mem_regwrite_i && int'(mem_rd_i) == idx) return mem_result_i;
      if (wb_regwrite_i && int'(wb_rd_i) == idx) return wb_result_i;
      return held;
   endfunction

   function automatic bit model_stall();
      return m.valid && m.memread && m.rd != 0 && id_valid_i &&
             (m.rd == int'(id_rs_i) || m.rd == int'(id_rt_i));
   endfunction

   function automatic ex_t model_next();
      ex_t n;
      n = '{default: 0};
      if (flush_i || model_stall()) return n;
      n.valid = id_valid_i; n.rs = int'(id_rs_i); n.rt = int'(id_rt_i); n.rd = int'(id_rd_i);
      n.rs_data = (wb_regwrite_i && wb_rd_i != 0 && wb_rd_i == id_rs_i) ? wb_result_i : id_rs_data_i;
      n.rt_data = (wb_regwrite_i && wb_rd_i != 0 && wb_rd_i == id_rt_i) ? wb_result_i : id_rt_data_i;
      n.imm = id_imm_i; n.alu = int'(id_alu_ctrl_i); n.alusrc = id_alusrc_i;
      n.regwrite = id_regwrite_i; n.memread = id_memread_i;
      n.memwrite = id_memwrite_i; n.memtoreg = id_memtoreg_i;
      return n;
   endfunction

   initial begin
      rst_i = 0;
      idle();
      #1;
      check_eq("reset_outputs", all_outs(), 64'h0);
      #1 rst_i = 1;

      // Back-to-back dependency and MEM/WB priority.
      set_id(1, 2, 3, 0, 0, ALU_ADD, 5'b01000);
      tick();
      check_eq("add_captured_rd", {59'h0, ex_valid_o, 4'(ex_rd_o)}, {59'h0, 1'b1, 4'd3});
      set_id(3, 5, 4, 0, 0, ALU_SUB, 5'b01000);
      tick();
      idle();
      mem_regwrite_i = 1; mem_rd_i = 3; mem_result_i = 32'h10;
      #1;
      check_eq("b2b_src1_mem", src1_o, 32'h10);
      check_eq("b2b_alu_ctrl", alu_ctrl_o, 4'd6);
      wb_regwrite_i = 1; wb_rd_i = 3; wb_result_i = 32'h20; mem_rd_i = 7;
      #1;
      check_eq("two_back_src1_wb", src1_o, 32'h20);
      mem_rd_i = 3;
      #1;
      check_eq("mem_over_wb_src1", src1_o, 32'h10);

      // Load-use: lw $2 in EX while ID reads $2.
      idle();
      set_id(1, 0, 2, 0, 0, ALU_ADD, 5'b11101);
      tick();
      set_id(2, 6, 8, 0, 0, ALU_ADD, 5'b01000);
      #1;
      check_eq("load_use_stall", stall_o, 1'b1);
      tick();
      check_eq("load_use_bubble", {ex_valid_o, ex_memread_o, stall_o}, 3'b000);
      tick();
      id_valid_i = 0;
      wb_regwrite_i = 1; wb_rd_i = 2; wb_result_i = 32'h55;
      #1;
      check_eq("load_use_resume_src1", {ex_valid_o, src1_o}, {1'b1, 32'h55});

      // $0 is never forwarded, neither at capture nor in EX.
      idle();
      set_id(0, 0, 9, 32'h77, 32'h0, ALU_ADD, 5'b01000);
      wb_regwrite_i = 1; wb_rd_i = 0; wb_result_i = 32'hBAD;
      tick();
      idle();
      mem_regwrite_i = 1; mem_rd_i = 0; mem_result_i = 32'hDEAD;
      wb_regwrite_i = 1; wb_rd_i = 0; wb_result_i = 32'hBAD;
      #1;
      check_eq("zero_reg_guard_src1", src1_o, 32'h77);

      // Flush coinciding with a load-use stall.
      idle();
      set_id(1, 0, 4, 0, 0, ALU_ADD, 5'b11101);
      tick();
      set_id(4, 1, 5, 0, 0, ALU_ADD, 5'b01010);
      flush_i = 1;
      #1;
      check_eq("flush_stall_still_high", stall_o, 1'b1);
      tick();
      check_eq("flush_bubble", {ex_valid_o, ex_regwrite_o, ex_memwrite_o}, 3'b000);

      // Asynchronous reset between edges.
      idle();
      set_id(1, 2, 6, 32'hAA, 32'hBB, ALU_OR, 5'b01000);
      tick();
      idle();
      #2;
      check_eq("pre_reset_valid", ex_valid_o, 1'b1);
      rst_i = 0;
      #1;
      check_eq("async_reset_outputs", all_outs(), 64'h0);
      @(negedge clk_i);
      rst_i = 1;
      set_id(1, 2, 6, 32'hAB, 32'hCD, ALU_OR, 5'b01000);
      tick();
      idle();
      #1;
      check_eq("post_reset_src1", src1_o, 32'hAB);
      check_eq("post_reset_src2", src2_o, 32'hCD);
      check_eq("post_reset_ctrl", ctrl_outs(), {1'b1, 5'd6, 4'd1, 4'b1000});

      // Randomized traffic against the model.
      rst_i = 0;
      #1;
      rst_i = 1;
      m = '{default: 0};
      for (int i = 0; i < 400; i++) begin
         id_valid_i     = ($urandom_range(0, 7) != 0);
         id_rs_i        = RW'($urandom_range(0, 7));
         id_rt_i        = RW'($urandom_range(0, 7));
         id_rd_i        = RW'($urandom_range(0, 7));
         id_rs_data_i   = $urandom;
         id_rt_data_i   = $urandom;
         id_imm_i       = $urandom;
         id_alu_ctrl_i  = 4'($urandom);
         id_alusrc_i    = 1'($urandom);
         id_regwrite_i  = 1'($urandom);
         id_memread_i   = ($urandom_range(0, 2) == 0);
         id_memwrite_i  = 1'($urandom);
         id_memtoreg_i  = 1'($urandom);
         flush_i        = ($urandom_range(0, 7) == 0);
         mem_regwrite_i = 1'($urandom);
         mem_rd_i       = RW'($urandom_range(0, 7));
         mem_result_i   = $urandom;
         wb_regwrite_i  = 1'($urandom);
         wb_rd_i        = RW'($urandom_range(0, 7));
         wb_result_i    = $urandom;
         #1;
         check_eq($sformatf("rnd%0d_stall", i), stall_o, model_stall());
         check_eq($sformatf("rnd%0d_src1", i), src1_o, newest(m.rs, m.rs_data));
         check_eq($sformatf("rnd%0d_src2", i), src2_o,
                  m.alusrc ? m.imm : newest(m.rt, m.rt_data));
         check_eq($sformatf("rnd%0d_store", i), store_data_o, newest(m.rt, m.rt_data));
         check_eq($sformatf("rnd%0d_ctrl", i), ctrl_outs(),
                  {m.valid, 5'(m.rd), 4'(m.alu), m.regwrite, m.memread, m.memwrite, m.memtoreg});
         m = model_next();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
